// File: rtl/data_sram_arbiter_if.sv
// Data SRAM sharing bus: two requesters (pipeline load/store and debug/DMA)
// on one side, the single-port data SRAM on the other.
// data_sram_rdata is not routed through the arbiter: both requesters read it
// directly and qualify it with their own rvalid.
interface data_sram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // CPU (pipeline) side
  logic              cpu_req;
  logic [DW/8-1:0]   cpu_wen;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              stallreq_mem;

  // Secondary (debug/DMA) side
  logic              dbg_req;
  logic [DW/8-1:0]   dbg_wen;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;

  // SRAM side
  logic              data_sram_en;
  logic [DW/8-1:0]   data_sram_wen;
  logic [AW-1:0]     data_sram_addr;
  logic [DW-1:0]     data_sram_wdata;
  logic [DW-1:0]     data_sram_rdata;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, stallreq_mem,
    input  dbg_req, dbg_wen, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  // Requester/SRAM environment view
  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, stallreq_mem,
    output dbg_req, dbg_wen, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_arbiter.sv
// Data SRAM port arbiter: fixed CPU priority with a bounded-starvation
// counter for the debug/DMA side, a registered read-return owner, and a
// combinational stall request for the pipeline when the CPU is denied.
module data_sram_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_sram_arbiter_if.slave bus
);

  // Counter must be at least one bit wide even when MAX_WAIT is 0.
  localparam int            CW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    RD_CPU,
    RD_DBG
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [CW-1:0]   w_wait_cnt_next;
  logic            w_dbg_wins;
  logic            w_cpu_gnt;
  logic            w_dbg_gnt;
  logic            w_sram_en;
  logic [DW/8-1:0] w_sram_wen;
  logic [AW-1:0]   w_sram_addr;
  logic [DW-1:0]   w_sram_wdata;

  // Grant decision: dbg wins alone or once it has waited MAX_WAIT cycles.
  always_comb begin
    w_dbg_wins = bus.dbg_req && (!bus.cpu_req || (r_wait_cnt == MAX_CNT));
    w_dbg_gnt  = !rst && w_dbg_wins;
    w_cpu_gnt  = !rst && bus.cpu_req && !w_dbg_wins;
  end

  // SRAM request mux: copy the winner, otherwise drive an idle, all-zero request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_sram_en    = 1'b0;
    w_sram_wen   = '0;
    w_sram_addr  = '0;
    w_sram_wdata = '0;
    if (w_cpu_gnt) begin
      w_sram_en    = 1'b1;
      w_sram_wen   = bus.cpu_wen;
      w_sram_addr  = bus.cpu_addr;
      w_sram_wdata = bus.cpu_wdata;
    end else if (w_dbg_gnt) begin
      w_sram_en    = 1'b1;
      w_sram_wen   = bus.dbg_wen;
      w_sram_addr  = bus.dbg_addr;
      w_sram_wdata = bus.dbg_wdata;
    end
  end

  // Starvation counter: clears when dbg is served or idle, saturates at MAX_WAIT.
  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if (!bus.dbg_req || w_dbg_gnt) begin
      w_wait_cnt_next = '0;
    end else if (r_wait_cnt != MAX_CNT) begin
      w_wait_cnt_next = r_wait_cnt + CW'(1);
    end
  end

  // Read-return owner: records who issued a read this cycle; writes leave it idle.
  always_comb begin
    w_next_state = IDLE;
    if (w_cpu_gnt && (bus.cpu_wen == '0)) begin
      w_next_state = RD_CPU;
    end else if (w_dbg_gnt && (bus.dbg_wen == '0)) begin
      w_next_state = RD_DBG;
    end
  end

  // State registers with synchronous reset; a read in flight at reset is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  assign bus.cpu_gnt         = w_cpu_gnt;
  assign bus.dbg_gnt         = w_dbg_gnt;
  assign bus.cpu_rvalid      = !rst && (r_state == RD_CPU);
  assign bus.dbg_rvalid      = !rst && (r_state == RD_DBG);
  assign bus.stallreq_mem    = bus.cpu_req && !w_cpu_gnt;
  assign bus.data_sram_en    = w_sram_en;
  assign bus.data_sram_wen   = w_sram_wen;
  assign bus.data_sram_addr  = w_sram_addr;
  assign bus.data_sram_wdata = w_sram_wdata;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Bench for data_sram_arbiter: MAX_WAIT=4 instance for most scenarios and a
// MAX_WAIT=0 instance for the dbg-always-wins case. Read returns are tracked
// by a scoreboard queue filled when a read grant is expected and drained by a
// negedge monitor that compares both rvalids every cycle.
module tb_data_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  typedef struct {
    int due;
    bit dbg;
  } rd_exp_t;

  rd_exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_arbiter_if #(.AW(32), .DW(32)) b4 ();
  data_sram_arbiter_if #(.AW(32), .DW(32)) b0 ();

  data_sram_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  data_sram_arbiter #(.AW(32), .DW(32), .MAX_WAIT(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  // Scoreboard monitor for the MAX_WAIT=4 instance.
  always @(negedge clk) begin : sb_monitor
    rd_exp_t    e;
    logic [1:0] exp_rv;
    exp_rv = 2'b00;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e      = sbq.pop_front();
      exp_rv = e.dbg ? 2'b01 : 2'b10;
    end
    n_total++;
    if ({b4.cpu_rvalid, b4.dbg_rvalid} !== exp_rv)
      $display("FAIL rvalid cyc %0d: got cpu/dbg=%b expected %b", cyc,
               {b4.cpu_rvalid, b4.dbg_rvalid}, exp_rv);
    else
      n_pass++;
  end

  task automatic push_rd(input bit is_dbg);
    sbq.push_back('{due: cyc + 1, dbg: is_dbg});
  endtask

  task automatic drive(input logic cr, input logic [3:0] cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk); #1;
    b4.cpu_req = cr; b4.cpu_wen = cw; b4.cpu_addr = ca; b4.cpu_wdata = cd;
    b4.dbg_req = dr; b4.dbg_wen = dw; b4.dbg_addr = da; b4.dbg_wdata = dd;
  endtask

  task automatic idle4();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      b4.cpu_req = 1'b1; b4.cpu_wen = 4'h0; b4.cpu_addr = 32'h10;
      b4.dbg_req = 1'b1; b4.dbg_wen = 4'h0; b4.dbg_addr = 32'h20;
      b0.cpu_req = 1'b1; b0.cpu_wen = 4'h0; b0.cpu_addr = 32'h10;
      b0.dbg_req = 1'b1; b0.dbg_wen = 4'h0; b0.dbg_addr = 32'h20;
      @(negedge clk);
      n_total++;
      if ({b4.cpu_gnt, b4.dbg_gnt, b4.data_sram_en, |b4.data_sram_wen} !== 4'b0000)
        $display("FAIL reset_dut4 cyc %0d: got gnt/en/wen=%b expected 0000", i,
                 {b4.cpu_gnt, b4.dbg_gnt, b4.data_sram_en, |b4.data_sram_wen});
      else n_pass++;
      n_total++;
      if ({b0.cpu_gnt, b0.dbg_gnt, b0.data_sram_en, b0.cpu_rvalid, b0.dbg_rvalid} !== 5'b0)
        $display("FAIL reset_dut0 cyc %0d: got %b expected 00000", i,
                 {b0.cpu_gnt, b0.dbg_gnt, b0.data_sram_en, b0.cpu_rvalid, b0.dbg_rvalid});
      else n_pass++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    b4.cpu_req = 1'b0; b4.dbg_req = 1'b0;
    b0.cpu_req = 1'b0; b0.dbg_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (b4.data_sram_en !== 1'b0)
      $display("FAIL reset_release_en: got %b expected 0", b4.data_sram_en);
    else n_pass++;
    idle4();
  endtask

  task automatic test_reset_drops_read();
    drive(1'b1, 4'h0, 32'h300, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    n_total++;
    if (b4.cpu_gnt !== 1'b1)
      $display("FAIL pre_reset_gnt: got %b expected 1", b4.cpu_gnt);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1; b4.cpu_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (b4.cpu_rvalid !== 1'b0)
      $display("FAIL rvalid_in_reset: got %b expected 0", b4.cpu_rvalid);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (b4.cpu_rvalid !== 1'b0)
      $display("FAIL rvalid_after_reset: got %b expected 0", b4.cpu_rvalid);
    else n_pass++;
    idle4();
  endtask

  task automatic test_cpu_read_write();
    drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    b4.data_sram_rdata = 32'hCAFE_0100;
    @(negedge clk);
    n_total++;
    if ({b4.cpu_gnt, b4.dbg_gnt, b4.stallreq_mem, b4.data_sram_en, b4.data_sram_wen,
         b4.data_sram_addr} !== {4'b1001, 4'h0, 32'h100})
      $display("FAIL cpu_read_issue: got gnt/stall/en=%b wen=%h addr=%h expected 1001/0/00000100",
               {b4.cpu_gnt, b4.dbg_gnt, b4.stallreq_mem, b4.data_sram_en},
               b4.data_sram_wen, b4.data_sram_addr);
    else n_pass++;
    push_rd(1'b0);
    drive(1'b1, 4'hF, 32'h204, 32'h1234_5678, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    n_total++;
    if ({b4.cpu_gnt, b4.data_sram_en, b4.data_sram_wen, b4.data_sram_addr, b4.data_sram_wdata}
        !== {2'b11, 4'hF, 32'h204, 32'h1234_5678})
      $display("FAIL cpu_write_issue: got gnt/en=%b wen=%h addr=%h wdata=%h expected 11/f/00000204/12345678",
               {b4.cpu_gnt, b4.data_sram_en}, b4.data_sram_wen, b4.data_sram_addr,
               b4.data_sram_wdata);
    else n_pass++;
    idle4();
    n_total++;
    if ({b4.data_sram_en, b4.data_sram_wen, b4.data_sram_addr, b4.data_sram_wdata} !== 69'b0)
      $display("FAIL idle_mux: got en=%b wen=%h addr=%h wdata=%h expected all 0",
               b4.data_sram_en, b4.data_sram_wen, b4.data_sram_addr, b4.data_sram_wdata);
    else n_pass++;
    idle4();
  endtask

  task automatic test_starvation();
    logic exp_d;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
      @(negedge clk);
      exp_d = ((i % 5) == 4);
      n_total++;
      if ({b4.cpu_gnt, b4.dbg_gnt, b4.stallreq_mem, b4.data_sram_en, b4.data_sram_addr}
          !== {!exp_d, exp_d, exp_d, 1'b1, exp_d ? 32'h20 : 32'h10})
        $display("FAIL starve cyc %0d: got gnt/stall/en=%b addr=%h expected %b addr=%h", i,
                 {b4.cpu_gnt, b4.dbg_gnt, b4.stallreq_mem, b4.data_sram_en}, b4.data_sram_addr,
                 {!exp_d, exp_d, exp_d, 1'b1}, exp_d ? 32'h20 : 32'h10);
      else n_pass++;
      push_rd(exp_d);
    end
    idle4();
  endtask

  task automatic test_dbg_restart();
    logic [8:0] dreq  = 9'b1_1111_1011;  // bit i = dbg_req in step i
    logic [8:0] dwins = 9'b0_1000_0000;  // bit i = dbg expected to win in step i
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'h0, 32'h30, 32'h0, dreq[i], 4'h0, 32'h40, 32'h0);
      @(negedge clk);
      n_total++;
      if ({b4.cpu_gnt, b4.dbg_gnt} !== {!dwins[i], dwins[i]})
        $display("FAIL restart step %0d: got cpu/dbg gnt=%b expected %b", i,
                 {b4.cpu_gnt, b4.dbg_gnt}, {!dwins[i], dwins[i]});
      else n_pass++;
      push_rd(dwins[i]);
    end
    idle4();
  endtask

  task automatic test_alternate();
    // {cpu_req, cpu_wen, cpu_addr[7:0], dbg_req, dbg_wen, dbg_addr[7:0]}
    logic [25:0] tbl [8] = '{
      {1'b1, 4'h0, 8'h40, 1'b0, 4'h0, 8'h00},
      {1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 8'h80},
      {1'b1, 4'h0, 8'h44, 1'b0, 4'h0, 8'h00},
      {1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 8'h84},
      {1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'h88},
      {1'b1, 4'h0, 8'h48, 1'b0, 4'h0, 8'h00},
      {1'b1, 4'h8, 8'h4C, 1'b0, 4'h0, 8'h00},
      {1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00}};
    logic [25:0] t;
    logic [3:0]  exp_wen;
    logic [31:0] exp_addr;
    for (int i = 0; i < 8; i++) begin
      t = tbl[i];
      drive(t[25], t[24:21], {24'h0, t[20:13]}, 32'hA5A5_0000, t[12], t[11:8],
            {24'h0, t[7:0]}, 32'h5A5A_0000);
      @(negedge clk);
      exp_wen  = t[25] ? t[24:21] : (t[12] ? t[11:8] : 4'h0);
      exp_addr = t[25] ? {24'h0, t[20:13]} : (t[12] ? {24'h0, t[7:0]} : 32'h0);
      n_total++;
      if ({b4.cpu_gnt, b4.dbg_gnt, b4.data_sram_wen, b4.data_sram_addr}
          !== {t[25], t[12], exp_wen, exp_addr})
        $display("FAIL alternate step %0d: got gnt=%b wen=%h addr=%h expected gnt=%b wen=%h addr=%h",
                 i, {b4.cpu_gnt, b4.dbg_gnt}, b4.data_sram_wen, b4.data_sram_addr,
                 {t[25], t[12]}, exp_wen, exp_addr);
      else n_pass++;
      if (t[25] && t[24:21] == 4'h0) push_rd(1'b0);
      if (t[12] && t[11:8] == 4'h0)  push_rd(1'b1);
    end
    idle4();
  endtask

  task automatic test_max_wait0();
    logic [4:0] exp [4] = '{5'b01100, 5'b01101, 5'b01101, 5'b00001};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      b0.cpu_req = (i < 3); b0.cpu_wen = 4'h0; b0.cpu_addr = 32'h50;
      b0.dbg_req = (i < 3); b0.dbg_wen = 4'h0; b0.dbg_addr = 32'h60;
      @(negedge clk);
      n_total++;
      if ({b0.cpu_gnt, b0.dbg_gnt, b0.stallreq_mem, b0.cpu_rvalid, b0.dbg_rvalid} !== exp[i])
        $display("FAIL max_wait0 step %0d: got gnt/stall/rv=%b expected %b", i,
                 {b0.cpu_gnt, b0.dbg_gnt, b0.stallreq_mem, b0.cpu_rvalid, b0.dbg_rvalid},
                 exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int          m_cnt = 0;
    logic        cr, dr, exp_c, exp_d;
    logic [3:0]  cw, dw, exp_wen;
    logic [31:0] ca, da, exp_addr;
    for (int i = 0; i < 60; i++) begin
      cr = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      cw = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      dw = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ca = $urandom & 32'h0000_FFFC;
      da = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
      drive(cr, cw, ca, $urandom, dr, dw, da, $urandom);
      @(negedge clk);
      exp_d    = dr && (!cr || m_cnt == 4);
      exp_c    = cr && !exp_d;
      exp_wen  = exp_c ? cw : (exp_d ? dw : 4'h0);
      exp_addr = exp_c ? ca : (exp_d ? da : 32'h0);
      n_total++;
      if ({b4.cpu_gnt, b4.dbg_gnt, b4.stallreq_mem, b4.data_sram_en, b4.data_sram_wen,
           b4.data_sram_addr} !== {exp_c, exp_d, cr && !exp_c, exp_c || exp_d, exp_wen, exp_addr})
        $display("FAIL random step %0d: got gnt/stall/en=%b wen=%h addr=%h expected %b wen=%h addr=%h",
                 i, {b4.cpu_gnt, b4.dbg_gnt, b4.stallreq_mem, b4.data_sram_en},
                 b4.data_sram_wen, b4.data_sram_addr,
                 {exp_c, exp_d, cr && !exp_c, exp_c || exp_d}, exp_wen, exp_addr);
      else n_pass++;
      if (exp_c && cw == 4'h0) push_rd(1'b0);
      if (exp_d && dw == 4'h0) push_rd(1'b1);
      if (!dr || exp_d)  m_cnt = 0;
      else if (m_cnt < 4) m_cnt++;
    end
    idle4();
  endtask

  initial begin
    rst = 1'b1;
    b4.cpu_req = 1'b0; b4.cpu_wen = 4'h0; b4.cpu_addr = 32'h0; b4.cpu_wdata = 32'h0;
    b4.dbg_req = 1'b0; b4.dbg_wen = 4'h0; b4.dbg_addr = 32'h0; b4.dbg_wdata = 32'h0;
    b4.data_sram_rdata = 32'h0;
    b0.cpu_req = 1'b0; b0.cpu_wen = 4'h0; b0.cpu_addr = 32'h0; b0.cpu_wdata = 32'h0;
    b0.dbg_req = 1'b0; b0.dbg_wen = 4'h0; b0.dbg_addr = 32'h0; b0.dbg_wdata = 32'h0;
    b0.data_sram_rdata = 32'h0;

    test_reset();
    test_reset_drops_read();
    test_cpu_read_write();
    test_starvation();
    test_dbg_restart();
    test_alternate();
    test_max_wait0();
    test_random();
    idle4();

    n_total++;
    if (sbq.size() !== 0)
      $display("FAIL sb_drain: got %0d read returns still pending expected 0", sbq.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
